// File: rtl/aes_block_packer.sv
// Input-side packer of the AES HWPE: gathers four 32-bit stream words into a
// 128-bit block, zero-pads the final partial block and flags it as last.
module aes_block_packer #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [31:0]        data_size_i,
  input  logic [WORD_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BLOCK_W-1:0] block_o,
  output logic               block_valid_o,
  input  logic               block_ready_i,
  output logic               block_last_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         bytes_left_q;
  logic [31:0]         words_left_q;
  logic [1:0]          word_idx_q;
  logic [BLOCK_W-1:0]  block_q;

  logic                word_xfer;
  logic                block_xfer;
  logic [WORD_W-1:0]   kept_word;
  logic [31:0]         bytes_taken;
  logic [31:0]         words_needed;

  assign word_xfer  = in_valid_i & in_ready_o;
  assign block_xfer = block_valid_o & block_ready_i;

  // 33-bit sum keeps a 0xFFFFFFFF-byte job from wrapping to zero words.
  assign words_needed = 32'(({1'b0, data_size_i} + 33'd3) >> 2);
  assign bytes_taken  = (bytes_left_q < 32'd4) ? bytes_left_q : 32'd4;

  // Only the valid low-order bytes of the final partial word survive.
  always_comb begin
    kept_word = in_data_i;
    if (bytes_left_q < 32'd4) begin
      case (bytes_left_q[1:0])
        2'd1:    kept_word = {24'h0, in_data_i[7:0]};
        2'd2:    kept_word = {16'h0, in_data_i[15:0]};
        2'd3:    kept_word = {8'h0, in_data_i[23:0]};
        default: kept_word = in_data_i;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    block_valid_o = 1'b0;
    block_last_o  = 1'b0;
    done_o        = 1'b0;
    busy_o        = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = (data_size_i == 32'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        in_ready_o = 1'b1;
        if (word_xfer && (word_idx_q == 2'd3 || words_left_q == 32'd1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        block_valid_o = 1'b1;
        block_last_o  = (words_left_q == 32'd0);
        if (block_ready_i) begin
          state_d = (words_left_q == 32'd0) ? DONE : FILL;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job counters and block register; the block is wiped at job start and
  // after every handoff so a short final block carries zeros in unused slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bytes_left_q <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      block_q      <= '0;
    end else if (clear_i) begin
      bytes_left_q <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      block_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bytes_left_q <= data_size_i;
            words_left_q <= words_needed;
            word_idx_q   <= '0;
            block_q      <= '0;
          end
        end
        FILL: begin
          if (word_xfer) begin
            case (word_idx_q)
              2'd0:    block_q[127:96] <= kept_word;
              2'd1:    block_q[95:64]  <= kept_word;
              2'd2:    block_q[63:32]  <= kept_word;
              default: block_q[31:0]   <= kept_word;
            endcase
            bytes_left_q <= bytes_left_q - bytes_taken;
            words_left_q <= words_left_q - 32'd1;
            word_idx_q   <= word_idx_q + 2'd1;
          end
        end
        HOLD: begin
          if (block_xfer) begin
            block_q    <= '0;
            word_idx_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign block_o = block_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: directed jobs push expected blocks,
// a negedge monitor pops and compares every accepted block.
module tb_aes_block_packer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clear_i;
  logic         start_i;
  logic [31:0]  data_size_i;
  logic [31:0]  in_data_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] block_o;
  logic         block_valid_o;
  logic         block_ready_i;
  logic         block_last_o;
  logic         busy_o;
  logic         done_o;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   word_cnt = 0;
  int   block_cnt = 0;

  aes_block_packer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .data_size_i   (data_size_i),
    .in_data_i     (in_data_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .block_last_o  (block_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes complete on the next rising edge, so sample at negedge.
  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (in_valid_i && in_ready_o) word_cnt++;
    if (block_valid_o && block_ready_i) begin
      block_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_block", block_o, 128'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("block_data", block_o, e.data);
        check("block_last", {127'h0, block_last_o}, {127'h0, e.last});
      end
    end
  end

  task automatic start_job(input logic [31:0] size);
    @(posedge clk_i); #1;
    start_i     = 1'b1;
    data_size_i = size;
    @(posedge clk_i); #1;
    start_i     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = w;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) break;
      n++;
      if (n > 100) begin
        check("word_timeout", 128'h0, 128'h1);
        break;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wait_done(input string name);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 60) begin
      @(negedge clk_i); #1;
      n++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check(name, 128'(done_cnt - base), 128'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, {127'h0, in_ready_o}, 128'h0);
    check({name, "_valid"}, {127'h0, block_valid_o}, 128'h0);
    check({name, "_last"},  {127'h0, block_last_o}, 128'h0);
    check({name, "_busy"},  {127'h0, busy_o}, 128'h0);
    check({name, "_done"},  {127'h0, done_o}, 128'h0);
    check({name, "_block"}, block_o, 128'h0);
  endtask

  initial begin
    int w0, b0;
    logic [31:0] t1_words [8];
    logic [31:0] t5_words [4];
    t1_words = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                 32'h01112233, 32'h05556677, 32'h0999AABB, 32'h0CDDEEFF};
    t5_words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h76543210};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; data_size_i = '0;
    in_data_i = '0; in_valid_i = 1'b0; block_ready_i = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(negedge clk_i); rst_i = 1'b0;

    // 32-byte job: two full blocks, second flagged last
    $display("[TB] two-block job");
    exp_q.push_back('{data: 128'h00112233_44556677_8899AABB_CCDDEEFF, last: 1'b0});
    exp_q.push_back('{data: 128'h01112233_05556677_0999AABB_0CDDEEFF, last: 1'b1});
    w0 = word_cnt;
    start_job(32'd32);
    for (int i = 0; i < 8; i++) send_word(t1_words[i]);
    in_data_i = 32'hFFFFFFFF;
    wait_done("t1_done_once");
    in_valid_i = 1'b0;
    check("t1_words", 128'(word_cnt - w0), 128'd8);

    // 21-byte job: last word keeps only its low byte
    $display("[TB] partial job");
    exp_q.push_back('{data: {4{32'hAABBCCDD}}, last: 1'b0});
    exp_q.push_back('{data: 128'hAABBCCDD_000000DD_00000000_00000000, last: 1'b1});
    w0 = word_cnt;
    start_job(32'd21);
    for (int i = 0; i < 6; i++) send_word(32'hAABBCCDD);
    wait_done("t2_done_once");
    in_valid_i = 1'b0;
    check("t2_words", 128'(word_cnt - w0), 128'd6);

    // zero-length job
    $display("[TB] zero-length job");
    w0 = word_cnt; b0 = block_cnt;
    in_valid_i = 1'b1; in_data_i = 32'h12345678;
    start_job(32'd0);
    check("t3_done_next", {127'h0, done_o}, 128'h1);
    wait_done("t3_done_once");
    in_valid_i = 1'b0;
    check("t3_no_words", 128'(word_cnt - w0), 128'd0);
    check("t3_no_block", 128'(block_cnt - b0), 128'd0);

    // engine back-pressure while a block is held
    $display("[TB] hold back-pressure");
    block_ready_i = 1'b0;
    exp_q.push_back('{data: 128'h11111111_22222222_33333333_44444444, last: 1'b1});
    w0 = word_cnt;
    start_job(32'd16);
    send_word(32'h11111111); send_word(32'h22222222);
    send_word(32'h33333333); send_word(32'h44444444);
    in_valid_i = 1'b1; in_data_i = 32'h55555555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("t4_hold_block", block_o, 128'h11111111_22222222_33333333_44444444);
      check("t4_hold_ctrl", {125'h0, block_valid_o, block_last_o, in_ready_o}, {125'h0, 3'b110});
    end
    @(posedge clk_i); #1;
    block_ready_i = 1'b1;
    wait_done("t4_done_once");
    in_valid_i = 1'b0;
    check("t4_words", 128'(word_cnt - w0), 128'd4);

    // asynchronous reset mid-fill, then a clean 16-byte job
    $display("[TB] reset mid-fill");
    b0 = done_cnt;
    start_job(32'd32);
    send_word(32'hCAFEF00D); send_word(32'hBAADF00D);
    in_valid_i = 1'b0;
    #3 rst_i = 1'b1;
    #1 check_idle_outputs("t5_async_rst");
    @(negedge clk_i); rst_i = 1'b0;
    check("t5_no_done", 128'(done_cnt - b0), 128'd0);
    exp_q.push_back('{data: 128'hDEADBEEF_01234567_89ABCDEF_76543210, last: 1'b1});
    start_job(32'd16);
    for (int i = 0; i < 4; i++) send_word(t5_words[i]);
    in_valid_i = 1'b0;
    wait_done("t5_done_once");

    // maximum length job: first three blocks are not last, then clear abandons it
    $display("[TB] max-length job");
    for (int b = 0; b < 3; b++) begin
      logic [31:0] base;
      base = 32'h10000000 * (b + 1);
      exp_q.push_back('{data: {base, base + 32'd1, base + 32'd2, base + 32'd3}, last: 1'b0});
    end
    b0 = done_cnt;
    start_job(32'hFFFFFFFF);
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 4; k++) send_word(32'h10000000 * (b + 1) + k);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("t6_busy", {127'h0, busy_o}, 128'h1);
    @(posedge clk_i); #1 clear_i = 1'b1;
    @(posedge clk_i); #1 clear_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("t6_clear");
    check("t6_no_done", 128'(done_cnt - b0), 128'd0);

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
